apb4_master: RTL

APB4_MASTER -- requirements
Module: apb4_master

---
 rtl/apb4_master.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/apb4_master.sv
// APB4 single-outstanding master: one command in, one registered APB transfer out,
// one response back, with an optional ACCESS-phase wait timeout.
module apb4_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    apb4_pclk,
    input  logic                    apb4_presetn,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
    input  logic [2:0]              req_prot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0]   apb4_paddr,
    output logic [2:0]              apb4_pprot,
    output logic                    apb4_psel,
    output logic                    apb4_penable,
    output logic                    apb4_pwrite,
    output logic [DATA_WIDTH-1:0]   apb4_pwdata,
    output logic [DATA_WIDTH/8-1:0] apb4_pstrb,
    input  logic                    apb4_pready,
    input  logic [DATA_WIDTH-1:0]   apb4_prdata,
    input  logic                    apb4_pslverr
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rerr_q, rerr_d;
    logic                  rto_q, rto_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pprot_d   = pprot_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        rto_d     = rto_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && ready_q) begin
                    state_d  = S_SETUP;
                    cnt_d    = '0;
                    paddr_d  = req_addr_i;
                    pprot_d  = req_prot_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_wdata_i;
                    pstrb_d  = req_write_i ? req_wstrb_i : '0;
                    psel_d   = 1'b1;
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                // A completing slave takes priority over a timeout in the same cycle.
                if (apb4_pready) begin
                    state_d   = S_RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = pwrite_q ? '0 : apb4_prdata;
                    rerr_d    = apb4_pslverr;
                    rto_d     = 1'b0;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d   = S_RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = '0;
                    rerr_d    = 1'b1;
                    rto_d     = 1'b1;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d  = S_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge apb4_pclk) begin
        if (!apb4_presetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            paddr_q   <= '0;
            pprot_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
            rto_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            paddr_q   <= paddr_d;
            pprot_q   <= pprot_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
            rto_q     <= rto_d;
        end
    end

    assign req_ready_o   = ready_q;
    assign apb4_paddr    = paddr_q;
    assign apb4_pprot    = pprot_q;
    assign apb4_psel     = psel_q;
    assign apb4_penable  = penable_q;
    assign apb4_pwrite   = pwrite_q;
    assign apb4_pwdata   = pwdata_q;
    assign apb4_pstrb    = pstrb_q;
    assign rsp_valid_o   = rvalid_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = rerr_q;
    assign rsp_timeout_o = rto_q;

endmodule
